// File: rtl/day2_pkg.sv
// Shared definitions for the Day 2 duplicate-sum pipeline: bound width,
// the ASCII bytes the range parser recognises, and the parser state type.
package day2_pkg;

    localparam int BIN_WIDTH = 64;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        S_LOWER,
        S_UPPER,
        S_DONE,
        S_ERROR
    } parse_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_newline(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal field accumulator: value <= value*10 + digit via shift-add, with
// a look-ahead of the next value and its overflow so the caller can decide.
module dec_accumulator #(
    parameter int BIN_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [3:0]           digit,
    output logic [BIN_WIDTH-1:0] value,
    output logic [BIN_WIDTH-1:0] value_next,
    output logic                 overflow
);

    logic [BIN_WIDTH+3:0] base;
    logic [BIN_WIDTH+3:0] wide;

    // Four guard bits hold 10*(2^W-1)+9 without wrapping.
    always_comb begin
        base = {4'b0000, value};
        wide = (base << 3) + (base << 1) + {{BIN_WIDTH{1'b0}}, digit};
    end

    assign overflow   = |wide[BIN_WIDTH+3:BIN_WIDTH];
    assign value_next = wide[BIN_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load && !overflow) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/day2_range_parser.sv
// ASCII "lower-upper,...\n" stream parser feeding the duplicate-sum core with
// one registered range strobe per parsed pair; malformed input is sticky.
module day2_range_parser
    import day2_pkg::parse_state_t, day2_pkg::S_LOWER, day2_pkg::S_UPPER,
           day2_pkg::S_DONE, day2_pkg::S_ERROR, day2_pkg::ASCII_DASH,
           day2_pkg::ASCII_COMMA, day2_pkg::is_digit, day2_pkg::is_newline;
#(
    parameter int BIN_WIDTH = day2_pkg::BIN_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [7:0]           i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [BIN_WIDTH-1:0] o_lower_bin,
    output logic [BIN_WIDTH-1:0] o_upper_bin,
    output logic                 o_last,
    output logic                 o_error,
    output logic [CNT_WIDTH-1:0] o_n_ranges
);

    parse_state_t         state;
    parse_state_t         state_next;
    logic                 has_digit;
    logic                 has_digit_next;
    logic [BIN_WIDTH-1:0] lower_q;

    logic                 accept;
    logic                 acc_clear;
    logic                 acc_load;
    logic [BIN_WIDTH-1:0] acc_value;
    logic [BIN_WIDTH-1:0] acc_value_next;
    logic                 acc_overflow;

    logic                 latch_lower;
    logic                 emit;
    logic                 emit_last;
    logic [BIN_WIDTH-1:0] emit_upper;
    logic                 go_error;

    assign accept = i_valid && o_ready;

    dec_accumulator #(
        .BIN_WIDTH(BIN_WIDTH)
    ) u_acc (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (acc_clear),
        .load      (acc_load),
        .digit     (i_data[3:0]),
        .value     (acc_value),
        .value_next(acc_value_next),
        .overflow  (acc_overflow)
    );

    always_comb begin
        state_next     = state;
        has_digit_next = has_digit;
        acc_clear      = 1'b0;
        acc_load       = 1'b0;
        latch_lower    = 1'b0;
        emit           = 1'b0;
        emit_last      = 1'b0;
        emit_upper     = acc_value;
        go_error       = 1'b0;

        if (accept) begin
            case (state)
                S_LOWER: begin
                    if (is_digit(i_data) && !i_last) begin
                        acc_load       = 1'b1;
                        has_digit_next = 1'b1;
                        go_error       = acc_overflow;
                    end else if (i_data == ASCII_DASH && has_digit && !i_last) begin
                        latch_lower    = 1'b1;
                        acc_clear      = 1'b1;
                        has_digit_next = 1'b0;
                        state_next     = S_UPPER;
                    end else begin
                        go_error = 1'b1;
                    end
                end
                S_UPPER: begin
                    if (is_digit(i_data)) begin
                        if (acc_overflow) begin
                            go_error = 1'b1;
                        end else if (i_last) begin
                            // Final digit of the file closes the range itself.
                            emit           = 1'b1;
                            emit_last      = 1'b1;
                            emit_upper     = acc_value_next;
                            acc_clear      = 1'b1;
                            has_digit_next = 1'b0;
                            state_next     = S_LOWER;
                        end else begin
                            acc_load       = 1'b1;
                            has_digit_next = 1'b1;
                        end
                    end else if (i_data == ASCII_COMMA && has_digit && !i_last) begin
                        emit           = 1'b1;
                        acc_clear      = 1'b1;
                        has_digit_next = 1'b0;
                        state_next     = S_LOWER;
                    end else if (is_newline(i_data) && has_digit) begin
                        emit           = 1'b1;
                        emit_last      = 1'b1;
                        acc_clear      = 1'b1;
                        has_digit_next = 1'b0;
                        state_next     = i_last ? S_LOWER : S_DONE;
                    end else begin
                        go_error = 1'b1;
                    end
                end
                S_DONE: begin
                    if (is_newline(i_data)) begin
                        state_next = i_last ? S_LOWER : S_DONE;
                    end else begin
                        go_error = 1'b1;
                    end
                end
                default: go_error = 1'b1;
            endcase

            if (emit && (lower_q > emit_upper)) begin
                emit     = 1'b0;
                go_error = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_LOWER;
            has_digit   <= 1'b0;
            lower_q     <= '0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_error     <= 1'b0;
            o_lower_bin <= '0;
            o_upper_bin <= '0;
            o_n_ranges  <= '0;
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (go_error) begin
                state   <= S_ERROR;
                o_error <= 1'b1;
                o_ready <= 1'b0;
            end else begin
                state     <= state_next;
                has_digit <= has_digit_next;
                if (latch_lower) begin
                    lower_q <= acc_value;
                end
                if (emit) begin
                    o_valid     <= 1'b1;
                    o_last      <= emit_last;
                    o_lower_bin <= lower_q;
                    o_upper_bin <= emit_upper;
                    o_n_ranges  <= o_n_ranges + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_day2_range_parser.sv
// Directed bench for day2_range_parser: hand-computed ranges, error cases,
// and mid-range reset recovery.
module tb_day2_range_parser;

    localparam int BW = 64;
    localparam int CW = 16;

    logic          i_clk;
    logic          i_reset;
    logic          i_valid;
    logic [7:0]    i_data;
    logic          i_last;
    logic          o_ready;
    logic          o_valid;
    logic [BW-1:0] o_lower_bin;
    logic [BW-1:0] o_upper_bin;
    logic          o_last;
    logic          o_error;
    logic [CW-1:0] o_n_ranges;

    int checks;
    int errors;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] up;
        logic        last;
    } rng_t;

    rng_t seen[$];

    day2_range_parser #(
        .BIN_WIDTH(BW),
        .CNT_WIDTH(CW)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_lower_bin(o_lower_bin),
        .o_upper_bin(o_upper_bin),
        .o_last     (o_last),
        .o_error    (o_error),
        .o_n_ranges (o_n_ranges)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_valid) begin
            seen.push_back('{lo: o_lower_bin, up: o_upper_bin, last: o_last});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic last);
        i_valid = 1'b1;
        i_data  = b;
        i_last  = last;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic send_str(input string s, input bit last_final);
        for (int i = 0; i < s.len(); i++) begin
            put(s[i], last_final && (i == s.len() - 1));
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        seen.delete();
    endtask

    task automatic chk_range(input string tag, input int idx, input logic [63:0] lo,
                             input logic [63:0] up, input logic last);
        if (idx >= seen.size()) begin
            chk({tag, "_present"}, 64'(seen.size()), 64'(idx + 1));
        end else begin
            chk({tag, "_lo"}, seen[idx].lo, lo);
            chk({tag, "_up"}, seen[idx].up, up);
            chk({tag, "_last"}, 64'(seen[idx].last), 64'(last));
        end
    endtask

    string bad_str[5] = '{"-3", "3--4", "3-4,,5-6", "3-x", "9-3,"};
    int    bad_idx[5] = '{0, 2, 4, 2, 3};
    int    bad_ok[5]  = '{0, 0, 1, 0, 0};

    initial begin
        checks  = 0;
        errors  = 0;
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_last  = 1'b0;
        #2;
        do_reset();

        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_error", 64'(o_error), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_lower", o_lower_bin, 64'd0);
        chk("rst_upper", o_upper_bin, 64'd0);
        chk("rst_count", 64'(o_n_ranges), 64'd0);

        send_str("11-22,95-115\n", 1'b1);
        @(posedge i_clk);
        #1;
        chk("two_count", 64'(seen.size()), 64'd2);
        chk_range("two_r0", 0, 64'd11, 64'd22, 1'b0);
        chk_range("two_r1", 1, 64'd95, 64'd115, 1'b1);
        chk("two_nranges", 64'(o_n_ranges), 64'd2);
        chk("two_error", 64'(o_error), 64'd0);
        seen.delete();

        send_str("5-", 1'b0);
        put("7", 1'b1);
        chk("lat_valid", 64'(o_valid), 64'd1);
        chk("lat_lower", o_lower_bin, 64'd5);
        chk("lat_upper", o_upper_bin, 64'd7);
        chk("lat_last", 64'(o_last), 64'd1);
        @(posedge i_clk);
        #1;
        chk("lat_valid_drop", 64'(o_valid), 64'd0);
        chk("lat_last_drop", 64'(o_last), 64'd0);
        chk("lat_hold_upper", o_upper_bin, 64'd7);
        seen.delete();
        send_str("1-2\n", 1'b1);
        @(posedge i_clk);
        #1;
        chk("file2_count", 64'(seen.size()), 64'd1);
        chk_range("file2", 0, 64'd1, 64'd2, 1'b1);
        chk("file2_nranges", 64'(o_n_ranges), 64'd4);

        do_reset();
        send_str("18446744073709551615-", 1'b0);
        chk("ovf_max_ok", 64'(o_error), 64'd0);
        send_str("1844674407370955161", 1'b0);
        chk("ovf_pre_error", 64'(o_error), 64'd0);
        put("6", 1'b0);
        chk("ovf_error", 64'(o_error), 64'd1);
        chk("ovf_ready", 64'(o_ready), 64'd0);
        chk("ovf_valid", 64'(o_valid), 64'd0);
        put("\n", 1'b1);
        chk("ovf_sticky", 64'(o_error), 64'd1);
        chk("ovf_no_emit", 64'(seen.size()), 64'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i <= bad_idx[v]; i++) begin
                if (i == bad_idx[v]) begin
                    chk({"bad_pre_", bad_str[v]}, 64'(o_error), 64'd0);
                end
                put(bad_str[v][i], 1'b0);
            end
            chk({"bad_err_", bad_str[v]}, 64'(o_error), 64'd1);
            chk({"bad_valid_", bad_str[v]}, 64'(o_valid), 64'd0);
            repeat (2) @(posedge i_clk);
            #1;
            chk({"bad_emits_", bad_str[v]}, 64'(seen.size()), 64'(bad_ok[v]));
        end

        do_reset();
        send_str("1-2", 1'b0);
        put("\r", 1'b0);
        chk("crlf_valid", 64'(o_valid), 64'd1);
        chk("crlf_lower", o_lower_bin, 64'd1);
        chk("crlf_upper", o_upper_bin, 64'd2);
        chk("crlf_last", 64'(o_last), 64'd1);
        put("\n", 1'b1);
        chk("crlf_lf_valid", 64'(o_valid), 64'd0);
        chk("crlf_lf_error", 64'(o_error), 64'd0);
        chk("crlf_nranges", 64'(o_n_ranges), 64'd1);

        send_str("123-4", 1'b0);
        #2;
        i_reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_error", 64'(o_error), 64'd0);
        chk("mid_rst_lower", o_lower_bin, 64'd0);
        chk("mid_rst_upper", o_upper_bin, 64'd0);
        chk("mid_rst_count", 64'(o_n_ranges), 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        chk("mid_rst_no_valid", 64'(o_valid), 64'd0);
        seen.delete();
        send_str("7-8", 1'b1);
        chk("mid_new_valid", 64'(o_valid), 64'd1);
        chk("mid_new_lower", o_lower_bin, 64'd7);
        chk("mid_new_upper", o_upper_bin, 64'd8);
        chk("mid_new_last", 64'(o_last), 64'd1);
        chk("mid_new_count", 64'(o_n_ranges), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
